logic_demux_pipe: RTL and testbench
===================================

LOGIC_DEMUX_PIPE -- requirements
Module: logic_demux_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 1..32).
REQ-002 SHALL have parameter NCH, default 4, giving the number of output channels (legal range 2..16).
REQ-003 SHALL have parameter CNTW, default 8, giving the width of each per-channel delivery counter.
REQ-004 clk  input  1  Single clock; all state updates on the rising edge.
REQ-005 rst  input  1  Reset, synchronous and active-high.
REQ-006 in_valid  input  1  Request present on a, b, op and dest.
REQ-007 in_ready  output  1  Block accepts the request this cycle.
REQ-008 a  input  WIDTH  Operand A.
REQ-009 b  input  WIDTH  Operand B.
REQ-010 op  input  3  Gate select: 0 NOT(a), 1 AND, 2 OR, 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 illegal.
REQ-011 dest  input  $clog2(NCH)  Destination channel index.
REQ-012 out_data  output  WIDTH  Registered result, shared across all channels.
REQ-013 out_valid  output  NCH  One-hot; bit d high means out_data is valid for channel d.
REQ-014 out_ready  input  NCH  Per-channel consumer ready.
REQ-015 err  output  1  Sticky flag for an illegal op or an out-of-range dest.
REQ-016 cnt_sel  input  $clog2(NCH)  Selects which delivery counter drives cnt_out.
REQ-017 cnt_out  output  CNTW  Delivery count of the channel selected by cnt_sel.

Function
REQ-018 A request SHALL be accepted on any cycle where in_valid and in_ready are both high.
- Result is computed bitwise across WIDTH.
- Result and dest are registered into a single output holding stage.
REQ-019 Latency SHALL be exactly 1 cycle.
- The cycle after acceptance, out_valid[dest] is high with the result.
- All other out_valid bits are 0.
REQ-020 in_ready SHALL equal (holding stage empty) OR (out_ready[held dest] high), so back-to-back transfers sustain full throughput.
REQ-021 While out_valid[d] is high and out_ready[d] is low, out_data and out_valid SHALL hold stable. Ready on other channels has no effect.
REQ-022 A transfer on channel d SHALL complete when out_valid[d] and out_ready[d] are both high.
- On completion, counter d increments by 1 and wraps from 2^CNTW-1 to 0.
REQ-023 Simultaneous completion and acceptance in the same cycle SHALL replace the held result with the new one, with no bubble and no loss.
REQ-024 op=7 SHALL still be accepted and delivered: the result is all zeros and err is set.
REQ-025 dest >= NCH SHALL be accepted and dropped: no out_valid is raised, no counter changes, and err is set.
REQ-026 err SHALL remain high until reset.
REQ-027 cnt_out SHALL be combinational from cnt_sel. A cnt_sel >= NCH SHALL read 0.

Reset
REQ-028 While rst is high at a clock edge, the following SHALL be cleared:
- holding stage empty; out_valid = 0, out_data = 0;
- err = 0;
- all counters = 0;
- in_ready = 0 during the reset cycle.
REQ-029 Reset mid-transfer SHALL discard the held result without a counter increment. in_ready SHALL be high on the first cycle after rst falls.

Structure
REQ-030 Op encodings (OP_NOT..OP_ILLEGAL) and the op field width SHALL live in the shared package logic_ops_pkg.
REQ-031 The bitwise gate evaluation SHALL be a purely combinational sub-module logic_unit (parameter WIDTH; ports a, b, op, y, illegal).
- The top level holds the handshake, demux, counters and err.

Verification
REQ-032 The bench SHALL cover the following scenarios (WIDTH=8, NCH=4):
- Reset: rst high for 2 cycles -> out_valid=0000, out_data=00, err=0, every cnt_out=0; in_ready=1 the cycle after release.
- Truth sweep: a=8'hF0, b=8'hCC, ops 0..6 to dest 2, out_ready=1111 -> out_valid=0100 one cycle later; data 0F, C0, FC, 3F, 03, 3C, C3; counter 2 = 7.
- Stall: op AND a=FF b=0F to dest 1, out_ready[1]=0 for 3 cycles with out_ready[0]=1 -> out_data holds 0F, out_valid=0010, in_ready=0; on release in_ready=1 and counter 1 = 1.
- Illegal: op=7 to dest 0 -> out_data=00, out_valid=0001, err=1 and stays 1 after later legal ops.
- Wrap: 256 OR transfers to dest 3 with continuous ready -> cnt_out(3)=0, no bubbles (256 transfers in 256 consecutive cycles).
- Reset mid-op: result held on dest 0 with ready low, rst pulsed -> out_valid=0000, counter 0 unchanged (0).

Source files
------------

// File: rtl/logic_ops_pkg.sv
// Shared gate encodings for the logic demux pipeline.
//   OP_W  : width of the op field carried on the request interface
//   op_e  : gate select codes; OP_ILLEGAL is accepted but yields zero
package logic_ops_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NOT     = 3'd0,
    OP_AND     = 3'd1,
    OP_OR      = 3'd2,
    OP_NAND    = 3'd3,
    OP_NOR     = 3'd4,
    OP_XOR     = 3'd5,
    OP_XNOR    = 3'd6,
    OP_ILLEGAL = 3'd7
  } op_e;

endpackage

// File: rtl/logic_unit.sv
// Purely combinational bitwise gate evaluator.
//   a, b    : WIDTH-bit operands (b ignored for OP_NOT)
//   op      : gate select (logic_ops_pkg::op_e encoding)
//   y       : WIDTH-bit result, all zeros for an illegal op
//   illegal : high when op does not name a gate
module logic_unit
  import logic_ops_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] y,
  output logic             illegal
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    y       = '0;
    illegal = 1'b0;
    case (op_e'(op))
      OP_NOT:  y = ~a;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/logic_demux_pipe.sv
// One-stage pipelined bitwise gate with a demultiplexed valid/ready output.
// A request (a, b, op, dest) is evaluated by logic_unit and captured into a
// single holding stage; the result is presented on the shared out_data with
// the valid bit of its destination channel raised. Each channel counts its
// completed transfers.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : request handshake
//   a, b, op, dest       : operands, gate select, destination channel
//   out_data / out_valid : held result and one-hot per-channel valid
//   out_ready            : per-channel consumer ready
//   err                  : sticky illegal-op / out-of-range-dest flag
//   cnt_sel / cnt_out    : combinational read port for delivery counters
module logic_demux_pipe
  import logic_ops_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int CNTW  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        a,
  input  logic [WIDTH-1:0]        b,
  input  logic [OP_W-1:0]         op,
  input  logic [$clog2(NCH)-1:0]  dest,
  output logic [WIDTH-1:0]        out_data,
  output logic [NCH-1:0]          out_valid,
  input  logic [NCH-1:0]          out_ready,
  output logic                    err,
  input  logic [$clog2(NCH)-1:0]  cnt_sel,
  output logic [CNTW-1:0]         cnt_out
);

  localparam int DW = $clog2(NCH);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [DW-1:0]    dest_q, dest_d;
  logic             err_q,  err_d;
  logic [CNTW-1:0]  cnt_q [NCH];
  logic [CNTW-1:0]  cnt_d [NCH];

  logic [WIDTH-1:0] unit_y;
  logic             unit_illegal;
  logic             accept;
  logic             complete;
  logic             dest_ok;

  logic_unit #(.WIDTH(WIDTH)) u_logic_unit (
    .a       (a),
    .b       (b),
    .op      (op),
    .y       (unit_y),
    .illegal (unit_illegal)
  );

  // The held result leaves in the same cycle a new one may enter, so the
  // stage accepts whenever it is empty or draining. Held low through reset.
  assign complete = full_q && out_ready[dest_q];
  assign in_ready = !rst && (!full_q || out_ready[dest_q]);
  assign accept   = in_valid && in_ready;
  assign dest_ok  = 32'(dest) < NCH;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    dest_d = dest_q;
    err_d  = err_q;
    for (int i = 0; i < NCH; i++) cnt_d[i] = cnt_q[i];

    if (complete) begin
      full_d         = 1'b0;
      cnt_d[dest_q]  = cnt_q[dest_q] + CNTW'(1);
    end

    // An out-of-range dest is consumed but never enters the holding stage.
    if (accept) begin
      err_d = err_q | unit_illegal | !dest_ok;
      if (dest_ok) begin
        full_d = 1'b1;
        data_d = unit_y;
        dest_d = dest;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
      dest_q <= '0;
      err_q  <= 1'b0;
      // NOTE: the counter array is a handful of flops, not a RAM, and must
      // read zero after reset, so every entry is cleared explicitly.
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so all state updates see the
      // pre-edge values regardless of statement order.
      full_q <= full_d;
      data_q <= data_d;
      dest_q <= dest_d;
      err_q  <= err_d;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    out_valid = '0;
    if (full_q) out_valid[dest_q] = 1'b1;
  end

  always_comb begin
    cnt_out = '0;
    if (32'(cnt_sel) < NCH) cnt_out = cnt_q[cnt_sel];
  end

  assign out_data = data_q;
  assign err      = err_q;

endmodule

// File: tb/tb_logic_demux_pipe.sv
// Self-checking bench for logic_demux_pipe (WIDTH=8, NCH=4, CNTW=8).
// Directed scenarios plus a randomized phase, all compared against a
// transaction-level model kept in the bench.
module tb_logic_demux_pipe;

  localparam int WIDTH = 8;
  localparam int NCH   = 4;
  localparam int CNTW  = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic [1:0]       dest;
  logic [WIDTH-1:0] out_data;
  logic [NCH-1:0]   out_valid;
  logic [NCH-1:0]   out_ready;
  logic             err;
  logic [1:0]       cnt_sel;
  logic [CNTW-1:0]  cnt_out;

  logic_demux_pipe #(.WIDTH(WIDTH), .NCH(NCH), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .dest      (dest),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err),
    .cnt_sel   (cnt_sel),
    .cnt_out   (cnt_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Transaction-level model: one pending result (or none), counts, err.
  bit         m_full;
  logic [7:0] m_data;
  logic [1:0] m_dest;
  bit         m_err;
  int         cnt_m [NCH];
  int         done_obs [NCH];

  logic [7:0] sweep_exp [7] = '{8'h0F, 8'hC0, 8'hFC, 8'h3F, 8'h03, 8'h3C, 8'hC3};

  // Per-bit gate evaluation by counting ones among the two inputs.
  function automatic logic [7:0] ref_gate(int o, logic [7:0] x, logic [7:0] y);
    logic [7:0] r;
    int ones;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      ones = int'(x[i]) + int'(y[i]);
      case (o)
        0:       r[i] = (x[i] == 1'b0);
        1:       r[i] = (ones == 2);
        2:       r[i] = (ones >= 1);
        3:       r[i] = (ones != 2);
        4:       r[i] = (ones == 0);
        5:       r[i] = (ones == 1);
        6:       r[i] = (ones != 1);
        default: r[i] = 1'b0;
      endcase
    end
    return r;
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_cnt(string tag, logic [1:0] ch, int exp);
    cnt_sel = ch;
    #1;
    check(tag, 32'(cnt_out), exp);
  endtask

  // One clock cycle: drive inputs, check in_ready, clock, advance the model,
  // then check the registered outputs.
  task automatic step(bit v, logic [7:0] ta, logic [7:0] tb, logic [2:0] top,
                      logic [1:0] td, logic [3:0] rdy);
    bit exp_ready;
    logic [3:0] fired;
    in_valid  = v;
    a         = ta;
    b         = tb;
    op        = top;
    dest      = td;
    out_ready = rdy;
    #1;
    exp_ready = !rst && (!m_full || rdy[m_dest]);
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    fired = out_valid & out_ready;
    @(posedge clk);
    #1;
    if (rst) begin
      m_full = 1'b0;
      m_data = '0;
      m_err  = 1'b0;
      for (int i = 0; i < NCH; i++) cnt_m[i] = 0;
    end else begin
      for (int i = 0; i < NCH; i++) if (fired[i]) done_obs[i]++;
      if (m_full && rdy[m_dest]) begin
        cnt_m[m_dest] = (cnt_m[m_dest] + 1) % 256;
        m_full = 1'b0;
      end
      if (v && exp_ready) begin
        if (top == 3'd7) m_err = 1'b1;
        m_full = 1'b1;
        m_dest = td;
        m_data = ref_gate(int'(top), ta, tb);
      end
    end
    check("out_valid", 32'(out_valid), m_full ? 32'(4'b0001 << m_dest) : 32'd0);
    if (m_full) check("out_data", 32'(out_data), 32'(m_data));
    check("err", 32'(err), 32'(m_err));
  endtask

  initial begin
    m_full = 1'b0;
    m_data = '0;
    m_dest = '0;
    m_err  = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      cnt_m[i]    = 0;
      done_obs[i] = 0;
    end
    cnt_sel = '0;

    // Reset held for two cycles.
    rst = 1'b1;
    step(0, 8'h00, 8'h00, 3'd0, 2'd0, 4'h0);
    step(0, 8'h00, 8'h00, 3'd0, 2'd0, 4'h0);
    check("rst_out_data", 32'(out_data), 32'h00);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    for (int c = 0; c < NCH; c++) check_cnt("rst_cnt", 2'(c), 0);
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", 32'(in_ready), 32'h1);

    // Truth sweep, back to back, to channel 2.
    for (int o = 0; o < 7; o++) begin
      step(1, 8'hF0, 8'hCC, 3'(o), 2'd2, 4'hF);
      check("sweep_valid", 32'(out_valid), 32'b0100);
      check("sweep_data", 32'(out_data), 32'(sweep_exp[o]));
    end
    step(0, 8'h00, 8'h00, 3'd0, 2'd0, 4'hF);
    check_cnt("sweep_cnt2", 2'd2, 7);

    // Stall on channel 1 while channel 0 is ready.
    step(1, 8'hFF, 8'h0F, 3'd1, 2'd1, 4'b0001);
    for (int k = 0; k < 3; k++) begin
      step(0, 8'h00, 8'h00, 3'd0, 2'd0, 4'b0001);
      check("stall_data", 32'(out_data), 32'h0F);
      check("stall_valid", 32'(out_valid), 32'b0010);
      check("stall_in_ready", 32'(in_ready), 32'h0);
    end
    out_ready = 4'hF;
    #1;
    check("stall_release_ready", 32'(in_ready), 32'h1);
    step(0, 8'h00, 8'h00, 3'd0, 2'd0, 4'hF);
    check_cnt("stall_cnt1", 2'd1, 1);

    // Illegal op to channel 0.
    step(1, 8'($urandom), 8'($urandom), 3'd7, 2'd0, 4'h0);
    check("illegal_data", 32'(out_data), 32'h00);
    check("illegal_valid", 32'(out_valid), 32'b0001);
    check("illegal_err", 32'(err), 32'h1);
    step(0, 8'h00, 8'h00, 3'd0, 2'd0, 4'hF);

    // Randomized legal traffic on channels 0..2; err must stay set.
    for (int k = 0; k < 60; k++) begin
      step(1'($urandom), 8'($urandom), 8'($urandom), 3'($urandom_range(0, 6)),
           2'($urandom_range(0, 2)), 4'($urandom));
    end
    step(0, 8'h00, 8'h00, 3'd0, 2'd0, 4'hF);
    check("err_sticky", 32'(err), 32'h1);
    for (int c = 0; c < 3; c++) check_cnt("rand_cnt", 2'(c), cnt_m[c]);

    // Counter wrap: 256 back-to-back OR transfers to channel 3.
    done_obs[3] = 0;
    for (int k = 0; k < 256; k++) begin
      step(1, 8'($urandom), 8'($urandom), 3'd2, 2'd3, 4'hF);
      check("wrap_in_ready", 32'(in_ready), 32'h1);
    end
    step(0, 8'h00, 8'h00, 3'd0, 2'd0, 4'hF);
    check("wrap_transfers", 32'(done_obs[3]), 32'd256);
    check_cnt("wrap_cnt3", 2'd3, 0);

    // Reset while a result is held with ready low.
    step(1, 8'hAA, 8'h55, 3'd1, 2'd0, 4'h0);
    check("midrst_held", 32'(out_valid), 32'b0001);
    rst = 1'b1;
    step(0, 8'h00, 8'h00, 3'd0, 2'd0, 4'h0);
    rst = 1'b0;
    check("midrst_valid", 32'(out_valid), 32'h0);
    step(0, 8'h00, 8'h00, 3'd0, 2'd0, 4'h0);
    check_cnt("midrst_cnt0", 2'd0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
